de_morgan_checker: RTL and testbench
====================================

DE_MORGAN_CHECKER -- requirements
Module: de_morgan_checker

Interface
REQ-001 Parameter LAW, default 2, selects the expected law: 1 = first law, y = ~(a|b); 2 = second law, y = ~(a&b).
REQ-002 Parameter NSAMPLES, default 10, range 1..255, is the number of qualified samples per run.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port start, input, 1, run request; honoured only in IDLE.
REQ-006 Port stop, input, 1, abort request; honoured only in RUN.
REQ-007 Port sample_en, input, 1, strobe marking a, b, y as stable and valid this cycle.
REQ-008 Ports a and b, input, 1 each, the stimulus applied to the device under check.
REQ-009 Port y, input, 1, the response of the device under check.
REQ-010 Port busy, output, 1, high while in RUN.
REQ-011 Port done, output, 1, one-cycle pulse at the end of a run.
REQ-012 Port pass, output, 1, verdict of the last completed run.
REQ-013 Port aborted, output, 1, set when the last run ended by stop.
REQ-014 Port err_cnt, output, 8, mismatch count of the current or last run.
REQ-015 Port cov, output, 4, input-combination coverage; bit index = {a,b}.
REQ-016 Port first_err, output, 3, {a,b,y} captured at the first mismatch of the run.
REQ-017 Port err_valid, output, 1, high once first_err holds a capture.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-019 IDLE -> RUN SHALL occur on start; entering RUN clears err_cnt, cov, first_err, err_valid, pass, aborted and the sample counter.
REQ-020 In RUN, each cycle with sample_en high SHALL compare y against the expected value of the selected LAW for the sampled a and b, and set cov[{a,b}].
REQ-021 On a mismatch, err_cnt SHALL increment and saturate at 255.
REQ-022 On the first mismatch of a run, first_err SHALL capture {a,b,y} and err_valid SHALL rise; later mismatches SHALL not overwrite the capture.
REQ-023 The sample that makes the count equal NSAMPLES SHALL be scored, and the FSM SHALL then move RUN -> DONE.
REQ-024 stop in RUN SHALL move the FSM to DONE with aborted = 1. If stop and sample_en arrive in the same cycle, stop wins and the sample is discarded.
REQ-025 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-026 pass SHALL be set in DONE to (err_cnt == 0) AND (cov == 4'hF) AND (not aborted).
REQ-027 pass, aborted, err_cnt, cov, first_err and err_valid SHALL hold their values through IDLE until the next start.
REQ-028 start in RUN or DONE SHALL be ignored.
REQ-029 sample_en in IDLE or DONE SHALL be ignored.
REQ-030 stop outside RUN SHALL be ignored.
REQ-031 Latency: a sample at edge N SHALL be reflected in err_cnt and cov after edge N; done follows the final sample by one cycle.

Reset
REQ-032 Assertion of rst_n low SHALL immediately force IDLE and set every output and the sample counter to 0, including mid-run.
REQ-033 The first start after deassertion SHALL behave as a fresh run.

Structure
REQ-034 Package de_morgan_pkg SHALL hold the LAW encodings (LAW_FIRST = 1, LAW_SECOND = 2) and the state enumeration.
REQ-035 Combinational sub-module de_morgan_ref (inputs a, b; output y_exp; parameter LAW) SHALL compute the expected value, and it is instantiated once.

Verification
REQ-036 LAW=2, y tied to ~(a&b); sample the sequence 00, 01, 10, 11 repeating for 10 samples -> done pulse, pass=1, err_cnt=0, cov=4'hF, err_valid=0.
REQ-037 LAW=2, y stuck at 0 -> first_err = 3'b000 captured at the first sample, err_cnt=3 for the 00, 01, 10 samples of the first 4-sample round, pass=0.
REQ-038 LAW=2, only 00 and 11 applied for 10 samples with a correct y -> err_cnt=0, cov=4'b1001, pass=0.
REQ-039 Assert stop together with sample_en on the 5th sample -> 4 samples scored, aborted=1, done pulses once, pass=0.
REQ-040 Drive rst_n low at sample 6 of a run -> all outputs read 0 immediately; the next start runs a clean 10-sample pass.
REQ-041 NSAMPLES=255 with y inverted -> err_cnt=255 with no wrap, first_err captured from the first sample.

Source files
------------

// File: rtl/de_morgan_pkg.sv
// Shared definitions for the De Morgan law checker.
// Holds the law selector encodings and the checker FSM state type.
package de_morgan_pkg;

  localparam int unsigned LAW_FIRST  = 1;  // y = ~(a | b)
  localparam int unsigned LAW_SECOND = 2;  // y = ~(a & b)

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;
  localparam logic [3:0] COV_FULL    = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/de_morgan_ref.sv
// Combinational reference for the selected De Morgan law.
// Ports:
//   a, b   - sampled stimulus
//   y_exp  - value the device under check should produce for a, b
module de_morgan_ref
  import de_morgan_pkg::*;
#(
  parameter int unsigned LAW = LAW_SECOND
) (
  input  logic a,
  input  logic b,
  output logic y_exp
);

  always_comb begin
    y_exp = 1'b0;
    if (LAW == LAW_FIRST) begin
      y_exp = ~(a | b);
    end else begin
      y_exp = ~(a & b);
    end
  end

endmodule

// File: rtl/de_morgan_checker.sv
// Run-based checker that scores a device's response y against a De Morgan law.
// A run starts on start, scores NSAMPLES qualified samples (sample_en) or ends
// early on stop, pulses done for one cycle and leaves a verdict behind.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, stop       - run request (IDLE only), abort request (RUN only)
//   sample_en, a, b, y- qualified sample of stimulus and response
//   busy, done        - in RUN, one-cycle end-of-run pulse
//   pass, aborted     - verdict of last run, last run ended by stop
//   err_cnt           - saturating mismatch count
//   cov               - seen input combinations, bit index {a,b}
//   first_err,err_valid - {a,b,y} of the first mismatch and its valid flag
module de_morgan_checker
  import de_morgan_pkg::*;
#(
  parameter int unsigned LAW      = LAW_SECOND,
  parameter int unsigned NSAMPLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       sample_en,
  input  logic       a,
  input  logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       aborted,
  output logic [7:0] err_cnt,
  output logic [3:0] cov,
  output logic [2:0] first_err,
  output logic       err_valid
);

  localparam logic [7:0] LastIdx = 8'(NSAMPLES - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [7:0] err_cnt_q;
  logic [3:0] cov_q;
  logic [2:0] first_err_q;
  logic       err_valid_q;
  logic       pass_q;
  logic       aborted_q;

  logic       y_exp;
  logic       mismatch;
  logic [3:0] cov_hit;
  logic [3:0] cov_next;

  de_morgan_ref #(
    .LAW (LAW)
  ) u_ref (
    .a     (a),
    .b     (b),
    .y_exp (y_exp)
  );

  assign mismatch = (y != y_exp);
  assign cov_hit  = 4'b0001 << {a, b};
  assign cov_next = cov_q | cov_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      err_cnt_q   <= 8'd0;
      cov_q       <= 4'd0;
      first_err_q <= 3'd0;
      err_valid_q <= 1'b0;
      pass_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StRun;
            cnt_q       <= 8'd0;
            err_cnt_q   <= 8'd0;
            cov_q       <= 4'd0;
            first_err_q <= 3'd0;
            err_valid_q <= 1'b0;
            pass_q      <= 1'b0;
            aborted_q   <= 1'b0;
          end
        end
        StRun: begin
          // stop takes priority; a coincident sample is dropped unscored
          if (stop) begin
            state_q   <= StDone;
            aborted_q <= 1'b1;
            pass_q    <= 1'b0;
          end else if (sample_en) begin
            cov_q <= cov_next;
            cnt_q <= cnt_q + 8'd1;
            if (mismatch) begin
              if (err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_q <= err_cnt_q + 8'd1;
              end
              if (!err_valid_q) begin
                first_err_q <= {a, b, y};
                err_valid_q <= 1'b1;
              end
            end
            if (cnt_q == LastIdx) begin
              state_q <= StDone;
              // Verdict includes the final sample, so it is valid with done
              pass_q  <= (err_cnt_q == 8'd0) && !mismatch && (cov_next == COV_FULL);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign aborted   = aborted_q;
  assign err_cnt   = err_cnt_q;
  assign cov       = cov_q;
  assign first_err = first_err_q;
  assign err_valid = err_valid_q;

endmodule

// File: tb/tb_de_morgan_checker.sv
// Randomized self-checking bench for de_morgan_checker.
// u_dut: LAW=2, NSAMPLES=10. u_dut_long: LAW=1, NSAMPLES=255.
module tb_de_morgan_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, sample_en, a, b, y;
  logic       busy, done, pass, aborted, err_valid;
  logic [7:0] err_cnt;
  logic [3:0] cov;
  logic [2:0] first_err;

  logic       start2, y2;
  logic       busy2, done2, pass2, aborted2, err_valid2;
  logic [7:0] err_cnt2;
  logic [3:0] cov2;
  logic [2:0] first_err2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  de_morgan_checker #(
    .LAW      (2),
    .NSAMPLES (10)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .sample_en (sample_en),
    .a         (a),
    .b         (b),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .aborted   (aborted),
    .err_cnt   (err_cnt),
    .cov       (cov),
    .first_err (first_err),
    .err_valid (err_valid)
  );

  de_morgan_checker #(
    .LAW      (1),
    .NSAMPLES (255)
  ) u_dut_long (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .stop      (stop),
    .sample_en (sample_en),
    .a         (a),
    .b         (b),
    .y         (y2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .aborted   (aborted2),
    .err_cnt   (err_cnt2),
    .cov       (cov2),
    .first_err (first_err2),
    .err_valid (err_valid2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".busy"},      32'(busy),      0);
    check_eq({tag, ".done"},      32'(done),      0);
    check_eq({tag, ".pass"},      32'(pass),      0);
    check_eq({tag, ".aborted"},   32'(aborted),   0);
    check_eq({tag, ".err_cnt"},   32'(err_cnt),   0);
    check_eq({tag, ".cov"},       32'(cov),       0);
    check_eq({tag, ".first_err"}, 32'(first_err), 0);
    check_eq({tag, ".err_valid"}, 32'(err_valid), 0);
  endtask

  // pat: 0 = 00,01,10,11 cycling; 1 = only 00/11; else random
  // ymode: 0 = correct, 1 = stuck 0, 2 = inverted, else random
  // stop_at / rst_at: 1-based sample number that carries stop / reset (0 = never)
  task automatic run1(input string tag, input int pat, input int ymode,
                      input int stop_at, input int rst_at);
    int         scored = 0;
    int         m_err  = 0;
    logic [3:0] m_cov  = 4'd0;
    logic [2:0] m_fe   = 3'd0;
    logic       m_valid = 1'b0;
    logic       m_abort = 1'b0;
    logic       m_pass;
    logic [1:0] ab;
    logic       ex, yy;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ".busy_start"}, 32'(busy), 1);
    check_eq({tag, ".err_clr"},    32'(err_cnt), 0);

    while (scored < 10) begin
      if ($urandom_range(3) == 0) begin
        sample_en = 1'b0;
        @(negedge clk);
      end
      case (pat)
        0:       ab = 2'(scored % 4);
        1:       ab = ($urandom_range(1) == 1) ? 2'b11 : 2'b00;
        default: ab = 2'($urandom_range(3));
      endcase
      ex = !((ab[1] == 1'b1) && (ab[0] == 1'b1));
      case (ymode)
        0:       yy = ex;
        1:       yy = 1'b0;
        2:       yy = !ex;
        default: yy = 1'($urandom_range(1));
      endcase
      {a, b} = ab;
      y = yy;
      sample_en = 1'b1;
      start = 1'($urandom_range(1));  // must be ignored while running
      if (rst_at == scored + 1) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero({tag, ".rst"});
        sample_en = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (stop_at == scored + 1) begin
        stop = 1'b1;
        m_abort = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        sample_en = 1'b0;
        start = 1'b0;
        break;
      end
      m_cov[ab] = 1'b1;
      if (yy != ex) begin
        if (m_err < 255) m_err++;
        if (!m_valid) begin
          m_valid = 1'b1;
          m_fe = {ab, yy};
        end
      end
      scored++;
      @(negedge clk);
      sample_en = 1'b0;
      start = 1'b0;
      check_eq({tag, ".err_cnt_run"}, 32'(err_cnt), 32'(m_err));
      check_eq({tag, ".cov_run"},     32'(cov),     32'(m_cov));
      if (scored < 10) check_eq({tag, ".busy_run"}, 32'(busy), 1);
    end

    m_pass = (m_err == 0) && (m_cov == 4'hF) && !m_abort;
    check_eq({tag, ".done"},      32'(done),      1);
    check_eq({tag, ".busy_done"}, 32'(busy),      0);
    check_eq({tag, ".pass"},      32'(pass),      32'(m_pass));
    check_eq({tag, ".aborted"},   32'(aborted),   32'(m_abort));
    check_eq({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err));
    check_eq({tag, ".cov"},       32'(cov),       32'(m_cov));
    check_eq({tag, ".err_valid"}, 32'(err_valid), 32'(m_valid));
    check_eq({tag, ".first_err"}, 32'(first_err), 32'(m_fe));

    // start during DONE is ignored; sample/stop in IDLE are ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ".done_once"}, 32'(done), 0);
    check_eq({tag, ".idle"},      32'(busy), 0);
    {a, b} = 2'b11;
    y = 1'b1;
    sample_en = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    stop = 1'b0;
    check_eq({tag, ".hold_busy"}, 32'(busy),    0);
    check_eq({tag, ".hold_err"},  32'(err_cnt), 32'(m_err));
    check_eq({tag, ".hold_ab"},   32'(aborted), 32'(m_abort));
    check_eq({tag, ".hold_pass"}, 32'(pass),    32'(m_pass));
  endtask

  task automatic run2();
    logic [3:0] m_cov = 4'd0;
    logic [2:0] m_fe  = 3'd0;
    logic [1:0] ab;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 255; i++) begin
      ab = 2'($urandom_range(3));
      {a, b} = ab;
      y2 = (ab != 2'b00);  // inverse of ~(a|b)
      if (i == 0) m_fe = {ab, y2};
      m_cov[ab] = 1'b1;
      sample_en = 1'b1;
      @(negedge clk);
      if (i == 99) check_eq("long.err_cnt_100", 32'(err_cnt2), 100);
    end
    sample_en = 1'b0;
    check_eq("long.done",      32'(done2),      1);
    check_eq("long.err_cnt",   32'(err_cnt2),   255);
    check_eq("long.first_err", 32'(first_err2), 32'(m_fe));
    check_eq("long.err_valid", 32'(err_valid2), 1);
    check_eq("long.cov",       32'(cov2),       32'(m_cov));
    check_eq("long.pass",      32'(pass2),      0);
    check_eq("long.aborted",   32'(aborted2),   0);
    @(negedge clk);
    check_eq("long.err_hold",  32'(err_cnt2),   255);
    check_eq("long.idle",      32'(busy2),      0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    sample_en = 1'b0;
    a = 1'b0;
    b = 1'b0;
    y = 1'b0;
    start2 = 1'b0;
    y2 = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run1("seq_ok",   0, 0, 0, 0);
    run1("stuck0",   0, 1, 0, 0);
    run1("diag",     1, 0, 0, 0);
    run1("abort",    2, 0, 5, 0);
    run1("midrst",   0, 1, 0, 6);
    run1("post_rst", 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) run1("rand", 2, 3, 0, 0);
    run2();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
